// File: rtl/mac_tile_pkg.sv
// Shared types and constants for the mac_tile_mc systolic-array tile.
package mac_tile_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOADED = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    localparam int unsigned INST_LOAD  = 0;
    localparam int unsigned INST_EXEC  = 1;
    localparam int unsigned INST_DRAIN = 2;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/mac_tile_mc_if.sv
// Neighbour-facing bus of one mac_tile_mc: west/north inputs, east/south outputs.
interface mac_tile_mc_if #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned lanes   = 2
);
    logic [lanes*bw-1:0] in_w;
    logic [2:0]          inst_w;
    logic                mode_select;
    logic [psum_bw-1:0]  in_n;
    logic [lanes*bw-1:0] out_e;
    logic [2:0]          inst_e;
    logic [psum_bw-1:0]  out_s;

    modport master (
        output in_w, inst_w, mode_select, in_n,
        input  out_e, inst_e, out_s
    );

    modport slave (
        input  in_w, inst_w, mode_select, in_n,
        output out_e, inst_e, out_s
    );
endinterface

// File: rtl/mac_dot.sv
// Combinational lanes-wide dot product: unsigned activations times signed weights.
module mac_dot #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned lanes   = 2
) (
    input  logic [lanes*bw-1:0]        a_i,
    input  logic [lanes*bw-1:0]        b_i,
    output logic signed [psum_bw-1:0]  dot_c
);
    localparam int unsigned PW = 2 * bw + 1;

    // Each product fits in PW bits; psum_bw is wide enough that the lane sum cannot overflow.
    always_comb begin
        dot_c = '0;
        for (int k = 0; k < int'(lanes); k++) begin
            dot_c = dot_c + psum_bw'(PW'($signed({1'b0, a_i[k*bw +: bw]}))
                                   * PW'($signed(b_i[k*bw +: bw])));
        end
    end
endmodule

// File: rtl/mac_tile_mc.sv
// Dual-mode (WS / OS) multi-lane MAC tile. Define MAC_TILE_SAT_EN to clamp the
// WS psum add and OS accumulate to the signed psum range instead of wrapping.
module mac_tile_mc
    import mac_tile_pkg::*;
#(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned lanes   = 2
) (
    input  logic         clk,
    input  logic         reset,
    mac_tile_mc_if.slave io
);
    localparam int unsigned LW = lanes * bw;

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [LW-1:0]      a_q, a_d;
    logic [LW-1:0]      b_q, b_d;
    logic [psum_bw-1:0] acc_q, acc_d;
    logic [psum_bw-1:0] out_s_q, out_s_d;
    logic [2:0]         inst_e_q, inst_e_d;

    logic [psum_bw-1:0] dot_ws_c, dot_os_c, acc_sum_c;
    logic [LW-1:0]      w_n_c;
    logic               mode_c, ld_c, ex_c, dr_c;

    function automatic logic [psum_bw-1:0] add_fn(input logic [psum_bw-1:0] x,
                                                  input logic [psum_bw-1:0] y);
`ifdef MAC_TILE_SAT_EN
        logic [psum_bw:0] s;
        s = {x[psum_bw-1], x} + {y[psum_bw-1], y};
        if (s[psum_bw] != s[psum_bw-1])
            add_fn = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
        else
            add_fn = s[psum_bw-1:0];
`else
        add_fn = x + y;
`endif
    endfunction

    assign w_n_c = io.in_n[LW-1:0];
    assign ld_c  = io.inst_w[INST_LOAD];
    assign ex_c  = io.inst_w[INST_EXEC];
    assign dr_c  = io.inst_w[INST_DRAIN];

    mac_dot #(.bw(bw), .psum_bw(psum_bw), .lanes(lanes)) u_dot_ws (
        .a_i   (io.in_w),
        .b_i   (b_q),
        .dot_c (dot_ws_c)
    );

    mac_dot #(.bw(bw), .psum_bw(psum_bw), .lanes(lanes)) u_dot_os (
        .a_i   (io.in_w),
        .b_i   (w_n_c),
        .dot_c (dot_os_c)
    );

    assign acc_sum_c = add_fn(acc_q, dot_os_c);

    // While EMPTY the live mode_select decides behaviour; afterwards the captured mode does.
    assign mode_c = (state_q == EMPTY) ? io.mode_select : mode_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        out_s_d  = io.in_n;
        inst_e_d = io.inst_w;

        if (state_q == EMPTY) mode_d = io.mode_select;
        if (state_q == DRAIN) state_d = LOADED;
        if (ld_c || ex_c) a_d = io.in_w;

        if (mode_c == MODE_WS) begin
            if (state_q == EMPTY) begin
                if (ld_c) begin
                    b_d                 = io.in_w;
                    state_d             = LOADED;
                    inst_e_d[INST_LOAD] = 1'b0;
                end
            end else if (ex_c) begin
                out_s_d = add_fn(io.in_n, dot_ws_c);
            end
        end else begin
            if (ex_c) begin
                b_d     = w_n_c;
                acc_d   = acc_sum_c;
                out_s_d = psum_bw'(w_n_c);
                if (state_q == EMPTY) state_d = LOADED;
            end
            // Drain wins the south port; a same-cycle exec is folded into the drained value.
            if (state_q == LOADED && dr_c) begin
                state_d = DRAIN;
                out_s_d = ex_c ? acc_sum_c : acc_q;
                acc_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            mode_q   <= MODE_WS;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            out_s_q  <= '0;
            inst_e_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            out_s_q  <= out_s_d;
            inst_e_q <= inst_e_d;
        end
    end

    assign io.out_e  = a_q;
    assign io.inst_e = inst_e_q;
    assign io.out_s  = out_s_q;
endmodule
